// File: rtl/led_blink_pkg.sv
// Shared mode encoding and prescaler sizing helpers for led_blink_ctrl.
package led_blink_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF     = 2'd0;
  localparam mode_t MODE_ON      = 2'd1;
  localparam mode_t MODE_BLINK   = 2'd2;
  localparam mode_t MODE_ONESHOT = 2'd3;

  function automatic int calc_div(input int clk_freq, input int tick_hz);
    return clk_freq / tick_hz;
  endfunction

  // Width of a counter/index over n values, never below one bit.
  function automatic int calc_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One LED channel: mode/period(/duty) registers, tick counter, led and done.
// BLINK_DUTY_EN selects duty-cycle BLINK instead of the 50 % toggle.
module blink_channel
  import led_blink_pkg::*;
#(
  parameter int PW = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          tick,
  input  logic          wr,
  input  mode_t         wr_mode,
  input  logic [PW-1:0] wr_period,
`ifdef BLINK_DUTY_EN
  input  logic [PW-1:0] wr_duty,
`endif
  output logic          led,
  output logic          done
);

  mode_t         mode, mode_nxt;
  logic [PW-1:0] period, c, c_nxt, c_inc, per_eff;
  logic          led_nxt, done_nxt, at_end;
`ifdef BLINK_DUTY_EN
  logic [PW-1:0] duty;
`endif

  // A programmed period of 0 behaves as 1.
  assign per_eff = (period == '0) ? PW'(1) : period;
  assign at_end  = (c >= per_eff - PW'(1));
  assign c_inc   = at_end ? '0 : c + PW'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) mode <= MODE_OFF;
    else        mode <= mode_nxt;
  end

  always_comb begin
    mode_nxt = mode;
    if (wr)                                          mode_nxt = wr_mode;
    else if (tick && mode == MODE_ONESHOT && at_end) mode_nxt = MODE_OFF;
  end

  // Write beats a coincident tick, so that tick is simply lost.
  always_comb begin
    c_nxt    = c;
    led_nxt  = led;
    done_nxt = 1'b0;
    if (wr) begin
      c_nxt   = '0;
`ifdef BLINK_DUTY_EN
      led_nxt = (wr_mode == MODE_BLINK) ? (wr_duty != '0) : (wr_mode != MODE_OFF);
`else
      led_nxt = (wr_mode != MODE_OFF);
`endif
    end else if (tick) begin
      case (mode)
        MODE_BLINK: begin
          c_nxt = c_inc;
`ifdef BLINK_DUTY_EN
          led_nxt = (c_inc < duty);
`else
          if (at_end) led_nxt = ~led;
`endif
        end
        MODE_ONESHOT: begin
          c_nxt = c_inc;
          if (at_end) begin
            led_nxt  = 1'b0;
            done_nxt = 1'b1;
          end
        end
        default: c_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      period <= '0;
      c      <= '0;
      led    <= 1'b0;
      done   <= 1'b0;
`ifdef BLINK_DUTY_EN
      duty   <= '0;
`endif
    end else begin
      c    <= c_nxt;
      led  <= led_nxt;
      done <= done_nxt;
      if (wr) begin
        period <= wr_period;
`ifdef BLINK_DUTY_EN
        duty   <= wr_duty;
`endif
      end
    end
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel LED blink controller: shared tick prescaler plus CH blink_channel
// instances. BLINK_DUTY_EN adds the wr_duty port and duty-cycle BLINK.
module led_blink_ctrl
  import led_blink_pkg::*;
#(
  parameter int CLK_FREQ = 125_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int CH       = 4,
  parameter int PW       = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  wr_en,
  input  logic [calc_w(CH)-1:0] wr_ch,
  input  mode_t                 wr_mode,
  input  logic [PW-1:0]         wr_period,
`ifdef BLINK_DUTY_EN
  input  logic [PW-1:0]         wr_duty,
`endif
  output logic                  tick,
  output logic [CH-1:0]         led,
  output logic [CH-1:0]         done
);

  localparam int DIV = calc_div(CLK_FREQ, TICK_HZ);
  localparam int DW  = calc_w(DIV);
  localparam int CHW = calc_w(CH);

  logic [DW-1:0] p;
  logic [CH-1:0] wr_sel;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p    <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (p == DW'(DIV - 1));
      p    <= (p == DW'(DIV - 1)) ? '0 : p + DW'(1);
    end
  end

  // Equality decode drops any wr_ch >= CH without touching a channel.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign wr_sel[i] = wr_en && (wr_ch == CHW'(i));

    blink_channel #(.PW(PW)) u_ch (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .tick      (tick),
      .wr        (wr_sel[i]),
      .wr_mode   (wr_mode),
      .wr_period (wr_period),
`ifdef BLINK_DUTY_EN
      .wr_duty   (wr_duty),
`endif
      .led       (led[i]),
      .done      (done[i])
    );
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl (DIV=10, CH=4, PW=8) with an abstract per-channel model;
// follows BLINK_DUTY_EN when defined.
module tb_led_blink_ctrl;

  localparam int DIV = 10;
  localparam int NCH = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [1:0] wr_mode = '0;
  logic [7:0] wr_period = '0;
  logic [7:0] wr_duty = '0;
  logic       tick;
  logic [3:0] led, done;

  logic       s_wr_en = 1'b0;
  logic [1:0] s_wr_ch = '0;
  logic [1:0] s_wr_mode = '0;
  logic [7:0] s_wr_period = '0;
  logic [7:0] s_wr_duty = '0;
  logic       s_tick;
  logic [2:0] s_led, s_done;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  always #5 CLK = ~CLK;

  led_blink_ctrl #(.CLK_FREQ(1000), .TICK_HZ(100), .CH(4), .PW(8)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_period(wr_period),
`ifdef BLINK_DUTY_EN
    .wr_duty(wr_duty),
`endif
    .tick(tick), .led(led), .done(done));

  // Three-channel instance so an out-of-range channel index is expressible.
  led_blink_ctrl #(.CLK_FREQ(1000), .TICK_HZ(100), .CH(3), .PW(8)) u_small (
    .CLK(CLK), .RST_N(RST_N), .wr_en(s_wr_en), .wr_ch(s_wr_ch), .wr_mode(s_wr_mode),
    .wr_period(s_wr_period),
`ifdef BLINK_DUTY_EN
    .wr_duty(s_wr_duty),
`endif
    .tick(s_tick), .led(s_led), .done(s_done));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Model: each channel remembers its mode and how many ticks it has seen since its
  // last write; outputs follow from that count arithmetically.
  int m_mode[NCH], m_per[NCH], m_duty[NCH], m_ticks[NCH];
  bit m_done[NCH];
  bit m_tick;
  int since;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_tick = 0;
      since  = 0;
      for (int i = 0; i < NCH; i++) begin
        m_mode[i] = 0; m_per[i] = 1; m_duty[i] = 0; m_ticks[i] = 0; m_done[i] = 0;
      end
    end else begin
      bit old_tick;
      old_tick = m_tick;
      since++;
      m_tick = (since % DIV == 0);
      for (int i = 0; i < NCH; i++) begin
        m_done[i] = 0;
        if (wr_en && int'(wr_ch) == i) begin
          m_mode[i]  = int'(wr_mode);
          m_per[i]   = (wr_period == 0) ? 1 : int'(wr_period);
          m_duty[i]  = int'(wr_duty);
          m_ticks[i] = 0;
        end else if (old_tick && (m_mode[i] == 2 || m_mode[i] == 3)) begin
          m_ticks[i]++;
          if (m_mode[i] == 3 && m_ticks[i] == m_per[i]) begin
            m_mode[i] = 0;
            m_done[i] = 1;
          end
        end
      end
    end
  end

  function automatic int m_led(input int i);
    case (m_mode[i])
      1, 3:    return 1;
`ifdef BLINK_DUTY_EN
      2:       return ((m_ticks[i] % m_per[i]) < m_duty[i]) ? 1 : 0;
`else
      2:       return ((m_ticks[i] / m_per[i]) % 2 == 0) ? 1 : 0;
`endif
      default: return 0;
    endcase
  endfunction

  always @(negedge CLK) begin
    chk("model_tick", int'(tick), int'(m_tick));
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("model_led%0d", i), int'(led[i]), m_led(i));
      chk($sformatf("model_done%0d", i), int'(done[i]), int'(m_done[i]));
    end
  end

  task automatic wait_cyc(input int k);
    int guard = 0;
    while (cyc != k && guard < 2000) begin
      @(negedge CLK);
      guard++;
    end
    if (cyc != k) begin
      n_chk++;
      $display("FAIL wait_cyc: got %0d expected %0d", cyc, k);
    end
  endtask

  task automatic wr(input int ch, input int mode, input int per, input int duty);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_mode = 2'(mode);
    wr_period = 8'(per); wr_duty = 8'(duty);
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  task automatic s_wr(input int ch, input int mode, input int per);
    s_wr_en = 1'b1; s_wr_ch = 2'(ch); s_wr_mode = 2'(mode);
    s_wr_period = 8'(per); s_wr_duty = 8'd1;
    @(negedge CLK);
    s_wr_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_led", int'(led), 0);
    chk("rst_tick", int'(tick), 0);
    RST_N = 1'b1;

    wait_cyc(9);  chk("tick_c9", int'(tick), 0);
    wait_cyc(10); chk("tick_c10", int'(tick), 1);
    wait_cyc(11); chk("tick_c11", int'(tick), 0);
    wait_cyc(20); chk("tick_c20", int'(tick), 1);
    wait_cyc(30); chk("tick_c30", int'(tick), 1); chk("idle_led", int'(led), 0);

    wait_cyc(41); wr(0, 2, 3, 1);
    wait_cyc(42); chk("blink0_start", int'(led[0]), 1);
    wr(2, 3, 2, 0);
    wait_cyc(60); chk("os2_on", int'(led[2]), 1); chk("os2_nodone", int'(done[2]), 0);
    wait_cyc(61); chk("os2_off", int'(led[2]), 0); chk("os2_done", int'(done), 4);
    wait_cyc(62); chk("os2_done_clr", int'(done[2]), 0);
    wait_cyc(70); chk("blink0_c70", int'(led[0]), 1);
    wait_cyc(71); chk("blink0_c71", int'(led[0]), 0);
    wait_cyc(101); chk("blink0_c101", int'(led[0]), 1);

    wait_cyc(110); chk("tick_c110", int'(tick), 1);
    wr(1, 2, 2, 1);
    wait_cyc(115); s_wr(3, 1, 1);
    wait_cyc(117); chk("oor_ignored", int'(s_led), 0);
    wait_cyc(118); s_wr(2, 1, 1);
    wait_cyc(120); chk("small_ch2_on", int'(s_led), 4);
    wait_cyc(130); chk("blink1_c130", int'(led[1]), 1);
    wait_cyc(131); chk("blink1_c131", int'(led[1]), 0);

    wait_cyc(141); wr(3, 2, 4, 1);
    wait_cyc(145); chk("os2_stays_off", int'(led[2]), 0);
`ifdef BLINK_DUTY_EN
    wait_cyc(150); chk("duty_c150", int'(led[3]), 1);
    wait_cyc(151); chk("duty_c151", int'(led[3]), 0);
    wait_cyc(180); chk("duty_c180", int'(led[3]), 0);
    wait_cyc(181); chk("duty_c181", int'(led[3]), 1);
    wait_cyc(191); chk("duty_c191", int'(led[3]), 0);
    wait_cyc(195); wr(3, 2, 4, 0);
    wait_cyc(196); chk("duty0_c196", int'(led[3]), 0);
    wait_cyc(240); chk("duty0_c240", int'(led[3]), 0);
    wait_cyc(241); wr(3, 2, 4, 9);
    wait_cyc(242); chk("duty9_c242", int'(led[3]), 1);
    wait_cyc(290); chk("duty9_c290", int'(led[3]), 1);
`else
    wait_cyc(180); chk("blink3_c180", int'(led[3]), 1);
    wait_cyc(181); chk("blink3_c181", int'(led[3]), 0);
`endif

    wait_cyc(300);
    chk("pre_rst_tick", int'(tick), 1);
    chk("pre_rst_led0", int'(led[0]), 1);
    #1 RST_N = 1'b0;
    #1;
    chk("async_rst_tick", int'(tick), 0);
    chk("async_rst_led", int'(led), 0);
    chk("async_rst_done", int'(done), 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    wait_cyc(9);  chk("re_tick_c9", int'(tick), 0);
    wait_cyc(10); chk("re_tick_c10", int'(tick), 1);
    wait_cyc(35); chk("re_idle_led", int'(led), 0);
    wait_cyc(41); wr(0, 2, 3, 1);
    wait_cyc(70); chk("re_blink0_c70", int'(led[0]), 1);
    wait_cyc(71); chk("re_blink0_c71", int'(led[0]), 0);
    wait_cyc(120);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
